mem_access_unit: RTL and testbench
==================================

Name: mem_access_unit

Overview:
Memory-stage load/store engine that consumes the control fields delivered by the M pipeline register: mem_read, mem_write and instruction_func, plus the address and store data.
- Issues one request per access on a valid/ready data-bus interface and waits for the response.
- Aligns and extends load data.
- Holds the pipeline with stall until the access completes.

Parameters:
ADDR_W, 32, data-bus address width
TIMEOUT_CYCLES, 64, cycles allowed in REQ+WAIT_RESP before abort (used only with MEM_TIMEOUT_EN)

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
op_valid  in  1  M-stage instruction valid
mem_read_in  in  1  load request from M register
mem_write_in  in  1  store request from M register
instruction_func_in  in  5  bits[2:0] = funct3 (access size/sign); bits[4:3] ignored
addr_in  in  ADDR_W  effective address (ALU result)
store_data_in  in  32  rs2 value
bus_req_valid  out  1  request valid
bus_req_ready  in  1  memory accepts request
bus_req_we  out  1  1 = write
bus_req_addr  out  ADDR_W  word-aligned address (addr[1:0] forced 0)
bus_req_wdata  out  32  lane-replicated store data
bus_req_wstrb  out  4  byte enables
bus_rsp_valid  in  1  response / write acknowledge
bus_rsp_rdata  in  32  read word
stall  out  1  freeze pipeline stages before WB
load_data  out  32  extended load result
load_valid  out  1  one-cycle pulse, load_data valid
access_err  out  1  one-cycle pulse: misaligned, illegal funct3, read&write both set, or timeout

Behaviour:
- Reset (async, rst_n=0): state IDLE, all outputs 0, latched fields and timeout counter cleared.
- FSM states: IDLE, REQ, WAIT_RESP, DONE.
- IDLE, op_valid & (rd|wr) & legal: latch addr, data, func and we; stall=1 combinationally in this same cycle; next state REQ.
- IDLE, op_valid & (rd|wr) & illegal: access_err=1 next cycle; no bus request; stall stays 0.
- Illegal conditions:
  - rd&wr both set.
  - Load funct3 not in {000,001,010,100,101}.
  - Store funct3 not in {000,001,010}.
  - Halfword with addr[0]=1.
  - Word with addr[1:0]!=0.
- REQ: bus_req_valid=1 with stable fields until bus_req_ready; on the handshake cycle go to WAIT_RESP; stall=1.
- WAIT_RESP: stall=1, bus_req_valid=0. On bus_rsp_valid go to DONE; for a load, register the extracted value into load_data.
- DONE: stall=0; load_valid=1 for loads only; next state IDLE. The pipeline advances on this cycle.
- Minimum access: ready in REQ and response next cycle gives stall high for 3 cycles (IDLE-capture, REQ, WAIT_RESP).
- Load extraction:
  - Byte = rdata >> (8*addr[1:0]), then bits[7:0].
  - Half = rdata >> (16*addr[1]), then bits[15:0].
  - LB/LH sign-extend; LBU/LHU zero-extend; LW passes the word through.
- Stores:
  - SB: wstrb = 4'b0001 << addr[1:0], wdata = {4{byte}}.
  - SH: wstrb = 4'b0011 << addr[1:0], wdata = {2{half}}.
  - SW: wstrb = 4'b1111.
- Loads drive wstrb=0 and wdata=0.
- bus_rsp_valid outside WAIT_RESP is ignored, including a stale response arriving after reset mid-operation.
- Inputs are ignored in every state except IDLE.
- load_data holds its value until the next load completes.

Optional Feature:
MEM_TIMEOUT_EN
- Defined:
  - A counter clears on entry to REQ and increments each cycle in REQ/WAIT_RESP.
  - On reaching TIMEOUT_CYCLES the FSM moves to IDLE, pulses access_err, drops stall and drives load_valid=0.
  - A late response is ignored.
- Undefined: no counter; the FSM waits indefinitely.

Decomposition:
- Package mem_access_pkg:
  - State enum.
  - funct3 constants F3_B/F3_H/F3_W/F3_BU/F3_HU.
  - Byte-lane helper functions.
- One natural sub-module, load_align_ext: combinational extraction and sign/zero extension from rdata, addr[1:0] and funct3.

Test Plan:
- LW at 0x100, ready=1, rdata=0xDEADBEEF next cycle → stall high 3 cycles, load_valid pulse, load_data=0xDEADBEEF.
- LB at 0x103, rdata=0x80123456 → load_data=0xFFFFFF80; LBU same → 0x00000080.
- SH at 0x202, data=0x0000ABCD → addr=0x200, wstrb=4'b1100, wdata=0xABCDABCD, we=1, load_valid stays 0.
- LW at 0x101 → access_err pulse, bus_req_valid never asserted, stall stays 0.
- bus_req_ready held low 5 cycles → bus_req_valid and fields stable, stall high throughout; then normal completion.
- rst_n asserted in WAIT_RESP then released → outputs 0, IDLE. A subsequent stray bus_rsp_valid gives no load_valid. With MEM_TIMEOUT_EN and TIMEOUT_CYCLES=8 and no response → access_err at cycle 8, stall drops.

Source files
------------

// File: rtl/mem_access_pkg.sv
// Shared types, funct3 encodings and byte-lane helpers for the memory-stage load/store engine.
package mem_access_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StReq,
    StWaitResp,
    StDone
  } state_e;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  function automatic logic load_f3_ok(input logic [2:0] f3);
    return f3 inside {F3_B, F3_H, F3_W, F3_BU, F3_HU};
  endfunction

  function automatic logic store_f3_ok(input logic [2:0] f3);
    return f3 inside {F3_B, F3_H, F3_W};
  endfunction

  // Natural alignment: f3[1:0] encodes the access size for every legal funct3.
  function automatic logic offset_ok(input logic [2:0] f3, input logic [1:0] off);
    logic ok;
    case (f3[1:0])
      2'b00:   ok = 1'b1;
      2'b01:   ok = ~off[0];
      2'b10:   ok = (off == 2'b00);
      default: ok = 1'b0;
    endcase
    return ok;
  endfunction

  function automatic logic [3:0] store_strb(input logic [2:0] f3, input logic [1:0] off);
    logic [3:0] strb;
    case (f3[1:0])
      2'b00:   strb = 4'b0001 << off;
      2'b01:   strb = 4'b0011 << off;
      default: strb = 4'b1111;
    endcase
    return strb;
  endfunction

  function automatic logic [31:0] store_wdata(input logic [2:0] f3, input logic [31:0] data);
    logic [31:0] wdata;
    case (f3[1:0])
      2'b00:   wdata = {4{data[7:0]}};
      2'b01:   wdata = {2{data[15:0]}};
      default: wdata = data;
    endcase
    return wdata;
  endfunction

  function automatic logic [7:0] extract_byte(input logic [31:0] word, input logic [1:0] off);
    logic [31:0] sh;
    sh = word >> {off, 3'b000};
    return sh[7:0];
  endfunction

  function automatic logic [15:0] extract_half(input logic [31:0] word, input logic hi);
    logic [31:0] sh;
    sh = word >> {hi, 4'b0000};
    return sh[15:0];
  endfunction

endpackage

// File: rtl/load_align_ext.sv
// Combinational load-data lane selection with sign or zero extension by funct3.
module load_align_ext
  import mem_access_pkg::*;
(
  input  logic [31:0] rdata_i,
  input  logic [1:0]  offset_i,
  input  logic [2:0]  funct3_i,
  output logic [31:0] data_o
);

  logic [7:0]  lane_b;
  logic [15:0] lane_h;

  always_comb begin
    lane_b = extract_byte(rdata_i, offset_i);
    lane_h = extract_half(rdata_i, offset_i[1]);
    case (funct3_i)
      F3_B:    data_o = {{24{lane_b[7]}}, lane_b};
      F3_BU:   data_o = {24'h000000, lane_b};
      F3_H:    data_o = {{16{lane_h[15]}}, lane_h};
      F3_HU:   data_o = {16'h0000, lane_h};
      default: data_o = rdata_i;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// Memory-stage load/store engine: one valid/ready bus request per access, stalls until done.
// Optional abort of hung accesses when MEM_TIMEOUT_EN is defined.
module mem_access_unit
  import mem_access_pkg::*;
#(
  parameter int unsigned ADDR_W         = 32,
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              op_valid,
  input  logic              mem_read_in,
  input  logic              mem_write_in,
  input  logic [4:0]        instruction_func_in,
  input  logic [ADDR_W-1:0] addr_in,
  input  logic [31:0]       store_data_in,
  output logic              bus_req_valid,
  input  logic              bus_req_ready,
  output logic              bus_req_we,
  output logic [ADDR_W-1:0] bus_req_addr,
  output logic [31:0]       bus_req_wdata,
  output logic [3:0]        bus_req_wstrb,
  input  logic              bus_rsp_valid,
  input  logic [31:0]       bus_rsp_rdata,
  output logic              stall,
  output logic [31:0]       load_data,
  output logic              load_valid,
  output logic              access_err
);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [2:0]        f3_q, f3_d;
  logic              we_q, we_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [3:0]        wstrb_q, wstrb_d;
  logic [31:0]       load_data_q, load_data_d;
  logic              err_q, err_d;

  logic [2:0]  f3_in;
  logic        access_req;
  logic        access_legal;
  logic [31:0] ext_data;
  logic        unused_func;

  assign f3_in       = instruction_func_in[2:0];
  assign unused_func = ^instruction_func_in[4:3];
  assign access_req  = op_valid & (mem_read_in | mem_write_in);

  always_comb begin
    access_legal = 1'b0;
    if (!(mem_read_in && mem_write_in)) begin
      access_legal = (mem_read_in ? load_f3_ok(f3_in) : store_f3_ok(f3_in)) &&
                     offset_ok(f3_in, addr_in[1:0]);
    end
  end

`ifdef MEM_TIMEOUT_EN
  localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT_CYCLES - 1);

  logic [CntW-1:0] cnt_q, cnt_d;
`else
  logic unused_timeout;
  assign unused_timeout = |TIMEOUT_CYCLES;
`endif

  load_align_ext u_load_align_ext (
    .rdata_i  (bus_rsp_rdata),
    .offset_i (addr_q[1:0]),
    .funct3_i (f3_q),
    .data_o   (ext_data)
  );

  always_comb begin
    state_d       = state_q;
    addr_d        = addr_q;
    f3_d          = f3_q;
    we_d          = we_q;
    wdata_d       = wdata_q;
    wstrb_d       = wstrb_q;
    load_data_d   = load_data_q;
    err_d         = 1'b0;
    stall         = 1'b0;
    bus_req_valid = 1'b0;
    load_valid    = 1'b0;
`ifdef MEM_TIMEOUT_EN
    cnt_d         = cnt_q;
`endif

    unique case (state_q)
      StIdle: begin
        if (access_req) begin
          if (access_legal) begin
            addr_d  = addr_in;
            f3_d    = f3_in;
            we_d    = mem_write_in;
            wstrb_d = mem_write_in ? store_strb(f3_in, addr_in[1:0]) : 4'b0000;
            wdata_d = mem_write_in ? store_wdata(f3_in, store_data_in) : 32'h0;
            stall   = 1'b1;
            state_d = StReq;
`ifdef MEM_TIMEOUT_EN
            cnt_d   = '0;
`endif
          end else begin
            err_d = 1'b1;
          end
        end
      end
      StReq: begin
        stall         = 1'b1;
        bus_req_valid = 1'b1;
        if (bus_req_ready) begin
          state_d = StWaitResp;
        end
      end
      StWaitResp: begin
        stall = 1'b1;
        if (bus_rsp_valid) begin
          if (!we_q) begin
            load_data_d = ext_data;
          end
          state_d = StDone;
        end
      end
      StDone: begin
        load_valid = ~we_q;
        state_d    = StIdle;
      end
      default: state_d = StIdle;
    endcase

`ifdef MEM_TIMEOUT_EN
    // A response in the final allowed cycle still completes the access.
    if (state_q == StReq || state_q == StWaitResp) begin
      cnt_d = cnt_q + 1'b1;
      if (cnt_q == CntLast && state_d != StDone) begin
        state_d = StIdle;
        err_d   = 1'b1;
      end
    end
`endif
  end

  // Request fields are only driven while the request is presented.
  always_comb begin
    bus_req_we    = 1'b0;
    bus_req_addr  = '0;
    bus_req_wdata = 32'h0;
    bus_req_wstrb = 4'b0000;
    if (state_q == StReq) begin
      bus_req_we    = we_q;
      bus_req_addr  = {addr_q[ADDR_W-1:2], 2'b00};
      bus_req_wdata = wdata_q;
      bus_req_wstrb = wstrb_q;
    end
  end

  assign load_data  = load_data_q;
  assign access_err = err_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      addr_q      <= '0;
      f3_q        <= 3'b000;
      we_q        <= 1'b0;
      wdata_q     <= 32'h0;
      wstrb_q     <= 4'b0000;
      load_data_q <= 32'h0;
      err_q       <= 1'b0;
`ifdef MEM_TIMEOUT_EN
      cnt_q       <= '0;
`endif
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      f3_q        <= f3_d;
      we_q        <= we_d;
      wdata_q     <= wdata_d;
      wstrb_q     <= wstrb_d;
      load_data_q <= load_data_d;
      err_q       <= err_d;
`ifdef MEM_TIMEOUT_EN
      cnt_q       <= cnt_d;
`endif
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Randomized self-checking bench for mem_access_unit against a behavioural access model.
module tb_mem_access_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        op_valid;
  logic        mem_read_in;
  logic        mem_write_in;
  logic [4:0]  instruction_func_in;
  logic [31:0] addr_in;
  logic [31:0] store_data_in;
  logic        bus_req_valid;
  logic        bus_req_ready;
  logic        bus_req_we;
  logic [31:0] bus_req_addr;
  logic [31:0] bus_req_wdata;
  logic [3:0]  bus_req_wstrb;
  logic        bus_rsp_valid;
  logic [31:0] bus_rsp_rdata;
  logic        stall;
  logic [31:0] load_data;
  logic        load_valid;
  logic        access_err;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;
  logic [31:0] exp_ld   = 32'h0;

  mem_access_unit #(
    .ADDR_W         (32),
    .TIMEOUT_CYCLES (8)
  ) dut (
    .clk                 (clk),
    .rst_n               (rst_n),
    .op_valid            (op_valid),
    .mem_read_in         (mem_read_in),
    .mem_write_in        (mem_write_in),
    .instruction_func_in (instruction_func_in),
    .addr_in             (addr_in),
    .store_data_in       (store_data_in),
    .bus_req_valid       (bus_req_valid),
    .bus_req_ready       (bus_req_ready),
    .bus_req_we          (bus_req_we),
    .bus_req_addr        (bus_req_addr),
    .bus_req_wdata       (bus_req_wdata),
    .bus_req_wstrb       (bus_req_wstrb),
    .bus_rsp_valid       (bus_rsp_valid),
    .bus_rsp_rdata       (bus_rsp_rdata),
    .stall               (stall),
    .load_data           (load_data),
    .load_valid          (load_valid),
    .access_err          (access_err)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // ---------------- reference model ----------------
  function automatic bit model_legal(input bit rd, input bit wr, input logic [2:0] f3,
                                     input logic [31:0] a);
    int unsigned nb;
    if (rd && wr) return 1'b0;
    if (rd && !(f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5})) return 1'b0;
    if (wr && !(f3 inside {3'd0, 3'd1, 3'd2})) return 1'b0;
    nb = 1 << f3[1:0];
    return (a % nb) == 0;
  endfunction

  function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [31:0] a,
                                             input logic [31:0] rdata);
    int unsigned off;
    longint v;
    off = a % 4;
    case (f3)
      3'd0, 3'd4: begin
        v = (rdata >> (8 * off)) & 32'hFF;
        if (f3 == 3'd0 && v >= 128) v -= 256;
      end
      3'd1, 3'd5: begin
        v = (rdata >> (16 * (off / 2))) & 32'hFFFF;
        if (f3 == 3'd1 && v >= 32768) v -= 65536;
      end
      default: v = rdata;
    endcase
    return v[31:0];
  endfunction

  function automatic logic [3:0] model_strb(input logic [2:0] f3, input logic [31:0] a);
    int unsigned nb;
    nb = 1 << f3[1:0];
    return 4'(((1 << nb) - 1) << (a % 4));
  endfunction

  function automatic logic [31:0] model_wdata(input logic [2:0] f3, input logic [31:0] d);
    int unsigned nb;
    logic [31:0] w;
    nb = 1 << f3[1:0];
    for (int k = 0; k < 4; k++) w[8*k +: 8] = 8'(d >> (8 * (k % nb)));
    return w;
  endfunction

  // Called one tick after a rising edge with the DUT idle.
  task automatic do_access(input bit rd, input bit wr, input logic [2:0] f3,
                           input logic [31:0] a, input logic [31:0] d,
                           input logic [31:0] rdata, input int rdly, input int sdly);
    bit          legal;
    logic [31:0] e_wdata;
    logic [3:0]  e_strb;
    legal   = (rd || wr) && model_legal(rd, wr, f3, a);
    e_strb  = wr ? model_strb(f3, a) : 4'b0000;
    e_wdata = wr ? model_wdata(f3, d) : 32'h0;
    check_eq("idle_valid", bus_req_valid, 1'b0);
    check_eq("idle_hold_ld", load_data, exp_ld);
    op_valid            = 1'b1;
    mem_read_in         = rd;
    mem_write_in        = wr;
    instruction_func_in = {2'($urandom_range(0, 3)), f3};
    addr_in             = a;
    store_data_in       = d;
    #1;
    check_eq("cap_stall", stall, legal);
    step();
    if (!legal) begin
      op_valid = 1'b0;
      check_eq("err_pulse", access_err, rd || wr);
      check_eq("err_noreq", bus_req_valid, 1'b0);
      check_eq("err_stall", stall, 1'b0);
      check_eq("err_lv", load_valid, 1'b0);
      step();
      check_eq("err_clr", access_err, 1'b0);
      check_eq("err_noreq2", bus_req_valid, 1'b0);
      return;
    end
    // Busy: the DUT must ignore whatever the pipeline presents now.
    op_valid            = 1'($urandom);
    mem_read_in         = 1'($urandom);
    mem_write_in        = 1'($urandom);
    instruction_func_in = 5'($urandom);
    addr_in             = $urandom;
    store_data_in       = $urandom;
    for (int i = 0; i <= rdly; i++) begin
      bus_req_ready = (i == rdly);
      check_eq("req_valid", bus_req_valid, 1'b1);
      check_eq("req_addr", bus_req_addr, a & ~32'h3);
      check_eq("req_we", bus_req_we, wr);
      check_eq("req_wstrb", bus_req_wstrb, e_strb);
      check_eq("req_wdata", bus_req_wdata, e_wdata);
      check_eq("req_stall", stall, 1'b1);
      step();
    end
    bus_req_ready = 1'b0;
    for (int i = 0; i <= sdly; i++) begin
      bus_rsp_valid = (i == sdly);
      bus_rsp_rdata = (i == sdly) ? rdata : $urandom;
      check_eq("wait_valid", bus_req_valid, 1'b0);
      check_eq("wait_stall", stall, 1'b1);
      check_eq("wait_lv", load_valid, 1'b0);
      step();
    end
    bus_rsp_valid = 1'b0;
    bus_rsp_rdata = $urandom;
    op_valid      = 1'b0;
    if (rd) exp_ld = model_load(f3, a, rdata);
    check_eq("done_stall", stall, 1'b0);
    check_eq("done_lv", load_valid, rd);
    check_eq("done_ld", load_data, exp_ld);
    check_eq("done_err", access_err, 1'b0);
    step();
    check_eq("post_lv", load_valid, 1'b0);
    check_eq("post_ld", load_data, exp_ld);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

  initial begin
    bit          rd, wr;
    logic [2:0]  f3;
    logic [31:0] a;
    int          kind;
    rst_n = 1'b1;
    op_valid = 1'b0; mem_read_in = 1'b0; mem_write_in = 1'b0;
    instruction_func_in = 5'h0; addr_in = 32'h0; store_data_in = 32'h0;
    bus_req_ready = 1'b0; bus_rsp_valid = 1'b0; bus_rsp_rdata = 32'h0;
    #2 rst_n = 1'b0;
    #2;
    check_eq("rst_stall", stall, 1'b0);
    check_eq("rst_valid", bus_req_valid, 1'b0);
    check_eq("rst_ld", load_data, 32'h0);
    check_eq("rst_lv", load_valid, 1'b0);
    check_eq("rst_err", access_err, 1'b0);
    check_eq("rst_wstrb", bus_req_wstrb, 4'b0000);
    step();
    step();
    rst_n = 1'b1;
    step();

    // Directed cases
    do_access(1, 0, 3'b010, 32'h100, 32'h0, 32'hDEADBEEF, 0, 0);
    do_access(1, 0, 3'b000, 32'h103, 32'h0, 32'h80123456, 0, 0);
    do_access(1, 0, 3'b100, 32'h103, 32'h0, 32'h80123456, 0, 1);
    do_access(0, 1, 3'b001, 32'h202, 32'h0000ABCD, 32'h0, 0, 0);
    do_access(1, 0, 3'b010, 32'h101, 32'h0, 32'h0, 0, 0);
    do_access(1, 0, 3'b001, 32'h306, 32'h0, 32'h8765F00D, 5, 0);
    do_access(1, 1, 3'b010, 32'h400, 32'h0, 32'h0, 0, 0);
    do_access(0, 1, 3'b100, 32'h400, 32'h0, 32'h0, 0, 0);

    // Reset while waiting for the response, then a stale response
    op_valid = 1'b1; mem_read_in = 1'b1; mem_write_in = 1'b0;
    instruction_func_in = 5'b00010; addr_in = 32'h500;
    bus_req_ready = 1'b1;
    step();
    op_valid = 1'b0;
    step();
    bus_req_ready = 1'b0;
    check_eq("rw_stall", stall, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    exp_ld = 32'h0;
    check_eq("arst_stall", stall, 1'b0);
    check_eq("arst_valid", bus_req_valid, 1'b0);
    check_eq("arst_ld", load_data, 32'h0);
    check_eq("arst_lv", load_valid, 1'b0);
    step();
    rst_n = 1'b1;
    bus_rsp_valid = 1'b1; bus_rsp_rdata = 32'h12345678;
    step();
    bus_rsp_valid = 1'b0;
    check_eq("stale_lv", load_valid, 1'b0);
    check_eq("stale_stall", stall, 1'b0);
    step();
    check_eq("stale_lv2", load_valid, 1'b0);
    check_eq("stale_ld", load_data, 32'h0);

`ifdef MEM_TIMEOUT_EN
    op_valid = 1'b1; mem_read_in = 1'b1; mem_write_in = 1'b0;
    instruction_func_in = 5'b00010; addr_in = 32'h40;
    #1;
    check_eq("to_cap_stall", stall, 1'b1);
    step();
    op_valid = 1'b0;
    bus_req_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      check_eq("to_stall", stall, 1'b1);
      check_eq("to_noerr", access_err, 1'b0);
      step();
      bus_req_ready = 1'b0;
    end
    check_eq("to_err", access_err, 1'b1);
    check_eq("to_stall_drop", stall, 1'b0);
    check_eq("to_lv", load_valid, 1'b0);
    bus_rsp_valid = 1'b1; bus_rsp_rdata = 32'hCAFEF00D;
    step();
    bus_rsp_valid = 1'b0;
    check_eq("to_late_lv", load_valid, 1'b0);
    check_eq("to_err_clr", access_err, 1'b0);
    step();
    check_eq("to_late_lv2", load_valid, 1'b0);
    check_eq("to_late_ld", load_data, exp_ld);
`endif

    // Randomized accesses
    for (int n = 0; n < 150; n++) begin
      if ($urandom_range(0, 3) == 0) begin
        bus_rsp_valid = 1'b1;
        bus_rsp_rdata = $urandom;
        step();
        bus_rsp_valid = 1'b0;
        check_eq("gap_lv", load_valid, 1'b0);
        check_eq("gap_stall", stall, 1'b0);
      end
      kind = $urandom_range(0, 9);
      if (kind == 0)      begin rd = 1; wr = 1; end
      else if (kind == 1) begin rd = 0; wr = 0; end
      else if (kind < 6)  begin rd = 1; wr = 0; end
      else                begin rd = 0; wr = 1; end
      f3 = 3'($urandom_range(0, 7));
      a  = $urandom;
      if ($urandom_range(0, 1) == 0) a = a & ~32'h3;
      do_access(rd, wr, f3, a, $urandom, $urandom,
                $urandom_range(0, 3), $urandom_range(0, 2));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
